// File: rtl/debouncer_pkg.sv
// debouncer_pkg: shared defaults and counter sizing for input_debouncer.
package debouncer_pkg;
    localparam int DEFAULT_STABLE_CYCLES = 4;
    localparam int DEFAULT_SYNC_STAGES = 2;
    function automatic int cnt_width(input int n);
        return ($clog2(n + 1) > 1) ? $clog2(n + 1) : 1;
    endfunction
endpackage

// File: rtl/bit_synchronizer.sv
// bit_synchronizer: plain flop chain bringing an asynchronous bit into the clk domain.
module bit_synchronizer
    import debouncer_pkg::*;
#(
    parameter int   STAGES      = DEFAULT_SYNC_STAGES,
    parameter logic RESET_VALUE = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic [STAGES-1:0] r_sync;
    always_ff @(posedge clk) begin
        if (rst) r_sync <= {STAGES{RESET_VALUE}};
        else     r_sync <= {r_sync[STAGES-2:0], d};
    end
    assign q = r_sync[STAGES-1];
endmodule

// File: rtl/input_debouncer.sv
// input_debouncer: synchronizer plus saturating stability counter; define
// DEBOUNCER_EDGE_PULSE_EN to add registered one-cycle rise/fall pulses.
module input_debouncer
    import debouncer_pkg::*;
#(
    parameter int   STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
    parameter int   SYNC_STAGES   = DEFAULT_SYNC_STAGES,
    parameter logic RESET_VALUE   = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic in,
    output logic out
`ifdef DEBOUNCER_EDGE_PULSE_EN
    ,
    output logic rise,
    output logic fall
`endif
);
    localparam int CW = cnt_width(STABLE_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(STABLE_CYCLES - 1);
    if (STABLE_CYCLES < 1 || SYNC_STAGES < 2) begin : g_bad_params
        $error("input_debouncer: STABLE_CYCLES must be >= 1 and SYNC_STAGES >= 2");
    end
    logic          w_sync_q;
    logic          w_differ;
    logic          w_done;
    logic          w_next_out;
    logic [CW-1:0] w_next_cnt;
    logic [CW-1:0] r_cnt;
    logic          r_out;
    bit_synchronizer #(.STAGES(SYNC_STAGES), .RESET_VALUE(RESET_VALUE)) u_sync (
        .clk(clk),
        .rst(rst),
        .d  (in),
        .q  (w_sync_q)
    );
    // Any cycle where the level matches out restarts stability counting from 0.
    always_comb begin
        w_differ   = w_sync_q != r_out;
        w_done     = w_differ && r_cnt == LAST;
        w_next_cnt = (!w_differ || w_done) ? '0 : r_cnt + CW'(1);
        w_next_out = w_done ? w_sync_q : r_out;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out <= RESET_VALUE;
            r_cnt <= '0;
        end else begin
            r_out <= w_next_out;
            r_cnt <= w_next_cnt;
        end
    end
    assign out = r_out;
`ifdef DEBOUNCER_EDGE_PULSE_EN
    logic r_rise;
    logic r_fall;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_rise <= w_done && w_sync_q;
            r_fall <= w_done && !w_sync_q;
        end
    end
    assign rise = r_rise;
    assign fall = r_fall;
`endif
endmodule

// File: tb/tb_input_debouncer.sv
// tb_input_debouncer: directed vectors queued per clock edge, checked by a separate monitor.
module tb_input_debouncer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_a = 1'b0;
    logic in_b = 1'b1;
    logic out_a;
    logic out_b;
`ifdef DEBOUNCER_EDGE_PULSE_EN
    logic rise_a, fall_a, rise_b, fall_b;
`endif
    always #5 clk = ~clk;
    input_debouncer u_a (
        .clk (clk),
        .rst (rst),
        .in  (in_a),
        .out (out_a)
`ifdef DEBOUNCER_EDGE_PULSE_EN
        ,
        .rise(rise_a),
        .fall(fall_a)
`endif
    );
    input_debouncer #(.STABLE_CYCLES(1), .SYNC_STAGES(3)) u_b (
        .clk (clk),
        .rst (rst),
        .in  (in_b),
        .out (out_b)
`ifdef DEBOUNCER_EDGE_PULSE_EN
        ,
        .rise(rise_b),
        .fall(fall_b)
`endif
    );
    typedef struct {
        string tag;
        bit    sel;
        logic  out;
        logic  rise;
        logic  fall;
    } exp_t;
    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;
    logic prev_a = 1'b0;
    logic prev_b = 1'b1;
    // One call = one rising edge; e is the out value expected right after it.
    task automatic step(input string tag, input bit sel, input logic r,
                        input logic ia, input logic ib, input logic e);
        exp_t x;
        logic p;
        @(negedge clk);
        rst  = r;
        in_a = ia;
        in_b = ib;
        p = sel ? prev_b : prev_a;
        x.tag  = tag;
        x.sel  = sel;
        x.out  = e;
        x.rise = !r && e && !p;
        x.fall = !r && !e && p;
        if (sel) prev_b = e;
        else     prev_a = e;
        sb.push_back(x);
    endtask
    task automatic rep(input string tag, input bit sel, input logic r,
                       input logic ia, input logic ib, input logic e, input int n);
        for (int i = 0; i < n; i++) step(tag, sel, r, ia, ib, e);
    endtask
    always @(posedge clk) begin
        exp_t x;
        logic ao, ar, af, ok;
        #1;
        if (sb.size() != 0) begin
            x  = sb.pop_front();
            ao = x.sel ? out_b : out_a;
            ok = ao === x.out;
`ifdef DEBOUNCER_EDGE_PULSE_EN
            ar = x.sel ? rise_b : rise_a;
            af = x.sel ? fall_b : fall_a;
            ok = ok && ar === x.rise && af === x.fall;
`else
            ar = x.rise;
            af = x.fall;
`endif
            vectors++;
            if (!ok) begin
                miscompares++;
                $display("FAIL %s dut%0d: out=%b rise=%b fall=%b, expected out=%b rise=%b fall=%b",
                         x.tag, x.sel, ao, ar, af, x.out, x.rise, x.fall);
            end
        end
    end
    initial begin
        logic [19:0] chat;
        chat = 20'b11001110011001110011;
        rep("reset", 0, 1, 1, 1, 0, 3);
        rep("release_wait", 0, 0, 1, 1, 0, 5);
        step("release_rise", 0, 0, 1, 1, 1);
        rep("hold_hi", 0, 0, 1, 1, 1, 2);
        rep("clean_fall_wait", 0, 0, 0, 1, 1, 5);
        step("clean_fall", 0, 0, 0, 1, 0);
        rep("hold_lo", 0, 0, 0, 1, 0, 3);
        rep("glitch3", 0, 0, 1, 1, 0, 3);
        rep("glitch3_reject", 0, 0, 0, 1, 0, 5);
        rep("glitch4", 0, 0, 1, 1, 0, 4);
        step("glitch4_wait", 0, 0, 0, 1, 0);
        step("glitch4_rise", 0, 0, 0, 1, 1);
        rep("glitch4_hold", 0, 0, 0, 1, 1, 3);
        step("glitch4_fall", 0, 0, 0, 1, 0);
        rep("glitch4_lo", 0, 0, 0, 1, 0, 2);
        for (int i = 19; i >= 0; i--) step("chatter", 0, 0, chat[i], 1, 0);
        rep("chatter_settle", 0, 0, 0, 1, 0, 4);
        rep("midcnt", 0, 0, 1, 1, 0, 3);
        step("midcnt_rst", 0, 1, 1, 1, 0);
        rep("midcnt_release", 0, 0, 1, 1, 0, 5);
        step("midcnt_rise", 0, 0, 1, 1, 1);
        rep("b_hi", 1, 0, 1, 1, 1, 2);
        rep("b_fall_wait", 1, 0, 1, 0, 1, 3);
        step("b_fall", 1, 0, 1, 0, 0);
        step("b_lo", 1, 0, 1, 0, 0);
        step("b_glitch", 1, 0, 1, 1, 0);
        rep("b_glitch_wait", 1, 0, 1, 0, 0, 2);
        step("b_glitch_rise", 1, 0, 1, 0, 1);
        step("b_glitch_fall", 1, 0, 1, 0, 0);
        step("b_lo2", 1, 0, 1, 0, 0);
        for (int i = 0; i < 5 && sb.size() != 0; i++) @(posedge clk);
        #2;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d vectors left unchecked, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
